if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the MIPS-32 datapath.
- Owns the program counter and drives the word-array instruction memory's read address.
- Registers each fetched instruction into an IF/ID pipeline stage that uses a valid/ready handshake toward decode.
- Handles start/halt control, branch/jump redirect with flush, and out-of-range fetch faults.
- Sits between the instruction memory (combinational read, raw byte address used as array index) and the decode stage.

---
 rtl/mips_pkg.sv | 15 +
 rtl/ifid_reg.sv | 52 +++++
 rtl/if_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 datapath blocks: fetch FSM encoding,
// instruction width and fixed constants.
package mips_pkg;

    localparam int                 INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds it under
// backpressure, clears on accept or flush.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               ready_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [ADDR_W-1:0]  pc_next_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_next_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_next_q;

    // Flush wins over load; the payload is only rewritten on load so a
    // stalled entry stays bit-for-bit stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP;
            pc_q      <= '0;
            pc_next_q <= '0;
        end else if (flush_i) begin
            valid_q   <= 1'b0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            pc_next_q <= pc_next_i;
        end else if (valid_q && ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory and
// feeds the IF/ID register; handles start/halt, redirect/flush and range faults.
module if_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 65,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               ifid_valid,
    input  logic               ifid_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count,
    output fetch_state_e       state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic is_run, in_range, slot_free;
    logic redirect_take, fetch_try, fetch_en, fault_trig;

    assign is_run        = (state_q == ST_RUN);
    assign in_range      = (pc_q <= LAST_ADDR);
    assign slot_free     = !ifid_valid || ifid_ready;
    assign redirect_take = is_run && redirect_valid;
    // A fetch "would occur" only when nothing blocks it except the address.
    assign fetch_try     = is_run && !redirect_valid && !halt && slot_free;
    assign fetch_en      = fetch_try && in_range;
    assign fault_trig    = fetch_try && !in_range;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE:  if (!halt && start) state_d = ST_RUN;
            ST_RUN: begin
                if (halt)            state_d = ST_IDLE;
                else if (fault_trig) state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        if (redirect_take)  pc_d = redirect_pc;
        else if (fetch_en)  pc_d = pc_q + PC_INC;

        if (fault_trig) fault_d = 1'b1;
        if (fetch_en)   count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (fetch_en),
        .flush_i   (redirect_take),
        .ready_i   (ifid_ready),
        .instr_i   (imem_instr),
        .pc_i      (pc_q),
        .pc_next_i (pc_q + PC_INC),
        .valid_o   (ifid_valid),
        .instr_o   (ifid_instr),
        .pc_o      (ifid_pc),
        .pc_next_o (ifid_pc_next)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: expected IF/ID entries are queued when a
// fetch is provoked and compared when the entry shows up on the outputs.
module tb_if_fetch_ctrl;
    import mips_pkg::*;

    localparam int DEPTH = 65;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               halt;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_instr;
    logic               ifid_valid;
    logic               ifid_ready;
    logic [31:0]        ifid_instr;
    logic [31:0]        ifid_pc;
    logic [31:0]        ifid_pc_next;
    logic               fetch_fault;
    logic [31:0]        fetch_count;
    fetch_state_e       state_dbg;

    logic [31:0] imem [0:DEPTH-1];
    logic [95:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'(DEPTH)) ? imem[imem_addr[6:0]] : 32'hdead_beef;

    if_fetch_ctrl #(.ADDR_W(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count),
        .state_dbg      (state_dbg)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, pc + 32'd4, imem[pc[6:0]]});
    endtask

    task automatic chk_head(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed no queued entry expected one", tag);
        end else begin
            chk({tag, ".valid"}, 96'(ifid_valid), 96'd1);
            chk({tag, ".pc"}, 96'(ifid_pc), 96'(exp_q[0][95:64]));
            chk({tag, ".pc_next"}, 96'(ifid_pc_next), 96'(exp_q[0][63:32]));
            chk({tag, ".instr"}, 96'(ifid_instr), 96'(exp_q[0][31:0]));
        end
    endtask

    task automatic pop_head();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".imem_addr"}, 96'(imem_addr), 96'd0);
        chk({tag, ".valid"}, 96'(ifid_valid), 96'd0);
        chk({tag, ".instr"}, 96'(ifid_instr), 96'd0);
        chk({tag, ".pc"}, 96'(ifid_pc), 96'd0);
        chk({tag, ".pc_next"}, 96'(ifid_pc_next), 96'd0);
        chk({tag, ".fault"}, 96'(fetch_fault), 96'd0);
        chk({tag, ".count"}, 96'(fetch_count), 96'd0);
        chk({tag, ".state"}, 96'(state_dbg), 96'(ST_IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) imem[i] = $urandom_range(32'hffff_fffe, 1);
        imem[0]  = 32'h0232_4020;
        imem[64] = 32'h0232_4020;

        reset = 1'b1; start = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; ifid_ready = 1'b1;

        // Reset and sequential fetch
        cyc(); cyc();
        reset = 1'b0;
        chk_reset("rst0");
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start.state", 96'(state_dbg), 96'(ST_RUN));
        chk("start.no_fetch", 96'(ifid_valid), 96'd0);
        chk("start.addr", 96'(imem_addr), 96'd0);
        for (int k = 0; k < 4; k++) push_fetch(32'(k * 4));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_head($sformatf("seq%0d", k));
            pop_head();
        end
        chk("seq.count", 96'(fetch_count), 96'd4);
        chk("seq.addr", 96'(imem_addr), 96'd16);

        // Backpressure, redirect, out-of-range fault
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset("rst1");
        start = 1'b1;
        cyc();
        start = 1'b0;
        push_fetch(32'd0);
        push_fetch(32'd4);
        cyc();
        chk_head("bp_pc0");
        pop_head();
        cyc();
        chk_head("bp_pc4");
        ifid_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_head($sformatf("bp_hold%0d", k));
            chk($sformatf("bp_hold%0d.addr", k), 96'(imem_addr), 96'd8);
        end
        ifid_ready = 1'b1;
        push_fetch(32'd8);
        cyc();
        pop_head();
        chk_head("bp_release");

        ifid_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd64;
        cyc();
        redirect_valid = 1'b0;
        redirect_pc = '0;
        chk("redir.flush", 96'(ifid_valid), 96'd0);
        chk("redir.addr", 96'(imem_addr), 96'd64);
        pop_head();
        push_fetch(32'd64);
        cyc();
        chk_head("redir_pc64");
        chk("redir.addr68", 96'(imem_addr), 96'd68);
        ifid_ready = 1'b1;
        cyc();
        pop_head();
        chk("fault.state", 96'(state_dbg), 96'(ST_FAULT));
        chk("fault.flag", 96'(fetch_fault), 96'd1);
        chk("fault.valid", 96'(ifid_valid), 96'd0);
        chk("fault.addr", 96'(imem_addr), 96'd68);
        chk("fault.count", 96'(fetch_count), 96'd4);
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        start = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        start = 1'b0;
        chk("fault_hold.addr", 96'(imem_addr), 96'd68);
        chk("fault_hold.state", 96'(state_dbg), 96'(ST_FAULT));
        chk("fault_hold.flag", 96'(fetch_fault), 96'd1);
        cyc();
        chk("fault_hold2.valid", 96'(ifid_valid), 96'd0);
        chk("fault_hold2.addr", 96'(imem_addr), 96'd68);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset("rst2");

        // Halt, restart, reset mid-operation
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 4; k++) push_fetch(32'(k * 4));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_head($sformatf("run%0d", k));
            pop_head();
        end
        halt = 1'b1;
        cyc();
        chk("halt.state", 96'(state_dbg), 96'(ST_IDLE));
        chk("halt.addr", 96'(imem_addr), 96'd16);
        chk("halt.drained", 96'(ifid_valid), 96'd0);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        cyc();
        chk("halt_over_start.state", 96'(state_dbg), 96'(ST_IDLE));
        chk("idle_redirect_ignored.addr", 96'(imem_addr), 96'd16);
        halt = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        start = 1'b0;
        chk("resume.state", 96'(state_dbg), 96'(ST_RUN));
        chk("resume.no_fetch", 96'(ifid_valid), 96'd0);
        for (int k = 0; k < 6; k++) push_fetch(32'(16 + k * 4));
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_head($sformatf("resume%0d", k));
            pop_head();
        end
        chk("resume.addr", 96'(imem_addr), 96'd40);
        chk("resume.count", 96'(fetch_count), 96'd10);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset("rst_mid");

        // Redirect and halt in the same cycle
        start = 1'b1;
        cyc();
        start = 1'b0;
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd32;
        cyc();
        halt = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_halt.state", 96'(state_dbg), 96'(ST_IDLE));
        chk("redir_halt.addr", 96'(imem_addr), 96'd32);
        chk("redir_halt.valid", 96'(ifid_valid), 96'd0);
        chk("queue.empty", 96'(exp_q.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
